// File: rtl/dm_load_unit_pkg.sv
// Shared encodings for the data-memory load path: load ops, exception codes, FSM states.
// Also holds the small legality/alignment helpers used at request time.
package dm_load_unit_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LB  = 3'b001,
    OP_LBU = 3'b010,
    OP_LH  = 3'b011,
    OP_LHU = 3'b100
  } ld_op_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_ILLEGAL  = 2'b10,
    EXC_TIMEOUT  = 2'b11
  } exc_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_LHU);
  endfunction

  // Byte loads can never be misaligned; halves need bit 0 clear, words both low bits.
  function automatic logic op_is_misaligned(input logic [2:0] op, input logic [1:0] lo);
    logic res;
    res = 1'b0;
    case (op)
      OP_LW:         res = (lo != 2'b00);
      OP_LH, OP_LHU: res = lo[0];
      default:       res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dm_load_unit_ext.sv
// Combinational lane select and sign/zero extension of a loaded word.
// Kept standalone so the writeback stage can reuse it.
module load_ext
  import dm_load_unit_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'b00:   w_byte = i_word[7:0];
      2'b01:   w_byte = i_word[15:8];
      2'b10:   w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    o_data = 32'h0;
    case (i_op)
      OP_LW:   o_data = i_word;
      OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_data = {24'h0, w_byte};
      OP_LH:   o_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_data = {16'h0, w_half};
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dm_load_unit.sv
// Load unit: validates a load request, issues one word read, waits (with timeout)
// for the data, and returns the extracted result or an exception code.
module dm_load_unit
  import dm_load_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_req,
  input  logic [2:0]  ld_op,
  input  logic [31:0] addr,
  input  logic [31:0] pc_in,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        ld_busy,
  output logic        ld_done,
  output logic [31:0] ld_data,
  output logic        ld_exc,
  output logic [1:0]  exc_code,
  output logic [31:0] pc_out
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e      r_state, w_state_next;
  exc_code_e   w_exc_next;
  logic [2:0]  r_op;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_pc;
  logic [CW-1:0] r_cnt;
  logic        r_mem_rd_en, r_busy, r_done, r_exc;
  logic [1:0]  r_exc_code;
  logic [31:0] r_mem_addr, r_ld_data, r_pc_out;
  logic [31:0] w_ext_data;

  load_ext u_load_ext (
    .i_op      (r_op),
    .i_addr_lo (r_addr_lo),
    .i_word    (mem_rdata),
    .o_data    (w_ext_data)
  );

  // Illegal op outranks misalignment; rvalid outranks the timeout.
  always_comb begin
    w_state_next = r_state;
    w_exc_next   = EXC_NONE;
    case (r_state)
      ST_IDLE: begin
        if (ld_req) begin
          if (!op_is_legal(ld_op)) begin
            w_state_next = ST_DONE;
            w_exc_next   = EXC_ILLEGAL;
          end else if (op_is_misaligned(ld_op, addr[1:0])) begin
            w_state_next = ST_DONE;
            w_exc_next   = EXC_MISALIGN;
          end else begin
            w_state_next = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (mem_rvalid) begin
          w_state_next = ST_DONE;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_state_next = ST_DONE;
          w_exc_next   = EXC_TIMEOUT;
        end
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_op        <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_pc        <= 32'h0;
      r_cnt       <= '0;
      r_mem_rd_en <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_exc       <= 1'b0;
      r_exc_code  <= EXC_NONE;
      r_mem_addr  <= 32'h0;
      r_ld_data   <= 32'h0;
      r_pc_out    <= 32'h0;
    end else begin
      r_state     <= w_state_next;
      r_busy      <= (w_state_next != ST_IDLE);
      r_mem_rd_en <= (w_state_next == ST_ISSUE);
      r_done      <= (w_state_next == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (ld_req) begin
            r_op      <= ld_op;
            r_addr_lo <= addr[1:0];
            r_pc      <= pc_in;
            if (w_state_next == ST_ISSUE) begin
              r_mem_addr <= {addr[31:2], 2'b00};
            end else begin
              r_ld_data  <= 32'h0;
              r_pc_out   <= pc_in;
              r_exc      <= 1'b1;
              r_exc_code <= w_exc_next;
            end
          end
        end
        ST_ISSUE: r_cnt <= '0;
        ST_WAIT: begin
          if (w_state_next == ST_DONE) begin
            r_pc_out   <= r_pc;
            r_exc      <= !mem_rvalid;
            r_exc_code <= w_exc_next;
            r_ld_data  <= mem_rvalid ? w_ext_data : 32'h0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_rd_en = r_mem_rd_en;
  assign mem_addr  = r_mem_addr;
  assign ld_busy   = r_busy;
  assign ld_done   = r_done;
  assign ld_data   = r_ld_data;
  assign ld_exc    = r_exc;
  assign exc_code  = r_exc_code;
  assign pc_out    = r_pc_out;

endmodule

// File: tb/tb_dm_load_unit.sv
// Directed self-checking bench for dm_load_unit: one line per load transaction.
module tb_dm_load_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_req;
  logic [2:0]  ld_op;
  logic [31:0] addr;
  logic [31:0] pc_in;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        ld_busy;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        ld_exc;
  logic [1:0]  exc_code;
  logic [31:0] pc_out;

  int n_cmp = 0;
  int n_err = 0;

  dm_load_unit #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_req     (ld_req),
    .ld_op      (ld_op),
    .addr       (addr),
    .pc_in      (pc_in),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .ld_busy    (ld_busy),
    .ld_done    (ld_done),
    .ld_data    (ld_data),
    .ld_exc     (ld_exc),
    .exc_code   (exc_code),
    .pc_out     (pc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the request cycle; rv_cyc is the cycle mem_rvalid is high (-1 = never).
  task automatic run_load(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] pc, input logic [31:0] word, input int rv_cyc,
                          input int exp_cyc, input logic [31:0] exp_data, input logic [1:0] exp_code);
    int done_cyc = -1;
    int rd_cnt = 0;
    logic [31:0] rd_addr = 32'h0;
    logic [31:0] got_data = 32'h0;
    logic [31:0] got_pc = 32'h0;
    logic [1:0]  got_code = 2'b00;
    logic        got_exc = 1'b0;
    logic        mem_expected;
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      ld_req     = (c == 0);
      ld_op      = op;
      addr       = a;
      pc_in      = pc;
      mem_rvalid = (c == rv_cyc);
      mem_rdata  = (c == rv_cyc) ? word : 32'hA5A5_A5A5;
      @(posedge clk);
      #1;
      if (mem_rd_en) begin
        rd_cnt++;
        rd_addr = mem_addr;
      end
      if (ld_done) begin
        done_cyc = c + 1;
        got_data = ld_data;
        got_pc   = pc_out;
        got_code = exc_code;
        got_exc  = ld_exc;
      end
    end
    @(negedge clk);
    ld_req     = 1'b0;
    mem_rvalid = 1'b0;
    $display("%s: done_cyc=%0d data=%h code=%0d exc=%0b pc=%h rd=%0d", tag, done_cyc,
             got_data, got_code, got_exc, got_pc, rd_cnt);
    mem_expected = (exp_code == 2'b00) || (exp_code == 2'b11);
    chk({tag, ".cyc"},  32'(done_cyc), 32'(exp_cyc));
    chk({tag, ".data"}, got_data, exp_data);
    chk({tag, ".code"}, {30'h0, got_code}, {30'h0, exp_code});
    chk({tag, ".exc"},  {31'h0, got_exc}, {31'h0, (exp_code != 2'b00)});
    chk({tag, ".pc"},   got_pc, pc);
    chk({tag, ".rdcnt"}, 32'(rd_cnt), mem_expected ? 32'd1 : 32'd0);
    if (mem_expected) chk({tag, ".maddr"}, rd_addr, {a[31:2], 2'b00});
    @(posedge clk);
    #1;
    chk({tag, ".pulse"}, {31'h0, ld_done}, 32'h0);
  endtask

  initial begin
    logic seen;
    int   n_done;
    int   done_cyc [2];
    logic [31:0] done_data [2];
    logic [31:0] done_pc [2];

    reset = 1'b0; ld_req = 1'b0; ld_op = 3'b000; addr = 32'h0; pc_in = 32'h0;
    mem_rdata = 32'h0; mem_rvalid = 1'b0;
    #1;
    chk("rst.busy",  {31'h0, ld_busy}, 32'h0);
    chk("rst.done",  {31'h0, ld_done}, 32'h0);
    chk("rst.rden",  {31'h0, mem_rd_en}, 32'h0);
    chk("rst.outs",  {ld_data | pc_out | mem_addr}, 32'h0);
    chk("rst.exc",   {29'h0, ld_exc, exc_code}, 32'h0);
    #19;
    reset = 1'b1;

    run_load("lb_b3",     3'b001, 32'h0000_0003, 32'h0000_1000, 32'h8012_3456, 2, 3, 32'hFFFF_FF80, 2'b00);
    run_load("lhu_h1",    3'b100, 32'h0000_0002, 32'h0000_1004, 32'h8001_7FFF, 2, 3, 32'h0000_8001, 2'b00);
    run_load("lh_h0",     3'b011, 32'h0000_0000, 32'h0000_1008, 32'h8001_7FFF, 2, 3, 32'h0000_7FFF, 2'b00);
    run_load("lw_mis",    3'b000, 32'h0000_0006, 32'h0000_100C, 32'h0,         -1, 1, 32'h0, 2'b01);
    run_load("op7_ill",   3'b111, 32'h0000_0006, 32'h0000_1010, 32'h0,         -1, 1, 32'h0, 2'b10);
    run_load("op5_prio",  3'b101, 32'h0000_0001, 32'h0000_1014, 32'h0,         -1, 1, 32'h0, 2'b10);
    run_load("lh_mis",    3'b011, 32'h0000_0001, 32'h0000_1018, 32'h0,         -1, 1, 32'h0, 2'b01);
    run_load("lbu_slow",  3'b010, 32'h0000_0002, 32'h0000_101C, 32'h8012_3456, 4, 5, 32'h0000_0012, 2'b00);
    run_load("lw_ok",     3'b000, 32'h0000_0020, 32'h0000_1020, 32'hDEAD_BEEF, 2, 3, 32'hDEAD_BEEF, 2'b00);
    run_load("lw_tmo",    3'b000, 32'h0000_0030, 32'h0000_1024, 32'h1234_5678, -1, 18, 32'h0, 2'b11);

    // A late rvalid while idle must not produce a completion.
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    chk("late.done", {31'h0, ld_done}, 32'h0);
    chk("late.busy", {31'h0, ld_busy}, 32'h0);
    @(negedge clk); mem_rvalid = 1'b0;

    // Reset while in WAIT, then a stale rvalid after release.
    ld_req = 1'b1; ld_op = 3'b000; addr = 32'h0000_0040; pc_in = 32'h0000_2000;
    @(negedge clk); ld_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort.busy", {31'h0, ld_busy}, 32'h0);
    chk("abort.done", {31'h0, ld_done}, 32'h0);
    chk("abort.maddr", mem_addr, 32'h0);
    chk("abort.pc", pc_out, 32'h0);
    @(negedge clk); reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk); mem_rvalid = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ld_done || ld_busy) seen = 1'b1;
    end
    $display("abort: stray activity after reset=%0b", seen);
    chk("abort.stray", {31'h0, seen}, 32'h0);
    run_load("lw_after", 3'b000, 32'h0000_0010, 32'h0000_2004, 32'hCAFE_BABE, 2, 3, 32'hCAFE_BABE, 2'b00);

    // Back-to-back: second request held high through the busy period.
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      ld_req = (c < 5);
      if (c == 0) begin
        ld_op = 3'b010; addr = 32'h0000_0001; pc_in = 32'h0000_0100;
      end else begin
        ld_op = 3'b011; addr = 32'h0000_0002; pc_in = 32'h0000_0104;
      end
      mem_rvalid = (c == 2) || (c == 6);
      mem_rdata  = (c == 2) ? 32'h1122_3344 : ((c == 6) ? 32'hFFFE_0000 : 32'h0);
      @(posedge clk); #1;
      if (ld_done) begin
        if (n_done < 2) begin
          done_cyc[n_done]  = c + 1;
          done_data[n_done] = ld_data;
          done_pc[n_done]   = pc_out;
        end
        n_done++;
      end
    end
    @(negedge clk); ld_req = 1'b0; mem_rvalid = 1'b0;
    $display("b2b: %0d completions", n_done);
    chk("b2b.count", 32'(n_done), 32'd2);
    if (n_done >= 2) begin
      chk("b2b.cyc0",  32'(done_cyc[0]), 32'd3);
      chk("b2b.data0", done_data[0], 32'h0000_0033);
      chk("b2b.pc0",   done_pc[0], 32'h0000_0100);
      chk("b2b.cyc1",  32'(done_cyc[1]), 32'd7);
      chk("b2b.data1", done_data[1], 32'hFFFF_FFFE);
      chk("b2b.pc1",   done_pc[1], 32'h0000_0104);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
